// File: rtl/axis_bram_loader.sv
// AXI4-Stream slave that writes one frame of nine-direction lattice populations
// into the per-direction BRAMs, one 144-bit beat per pixel address.
`timescale 1ns/1ps

module axis_bram_loader #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                       s00_axis_aclk,
    input  logic                       s00_axis_aresetn,
    input  logic                       load_start,
    input  logic                       bram_hold,
    input  logic                       s00_axis_tvalid,
    output logic                       s00_axis_tready,
    input  logic [9*DATA_WIDTH-1:0]    s00_axis_tdata,
    input  logic [9*DATA_WIDTH/8-1:0]  s00_axis_tstrb,
    input  logic                       s00_axis_tlast,
    output logic                       write_en,
    output logic [ADDRESS_WIDTH-1:0]   write_addr,
    output logic [DATA_WIDTH-1:0]      null_o,
    output logic [DATA_WIDTH-1:0]      n_o,
    output logic [DATA_WIDTH-1:0]      ne_o,
    output logic [DATA_WIDTH-1:0]      e_o,
    output logic [DATA_WIDTH-1:0]      se_o,
    output logic [DATA_WIDTH-1:0]      s_o,
    output logic [DATA_WIDTH-1:0]      sw_o,
    output logic [DATA_WIDTH-1:0]      w_o,
    output logic [DATA_WIDTH-1:0]      nw_o,
    output logic                       load_done,
    output logic                       length_error,
    output logic                       strb_error
);

    localparam int BEAT_WIDTH = 9 * DATA_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] count;
    logic [BEAT_WIDTH-1:0]    beat_q;
    logic                     accept;
    logic                     at_last;
    logic                     strb_ok;

    assign accept  = s00_axis_tvalid && s00_axis_tready;
    assign at_last = (count == LAST_ADDR);
    assign strb_ok = &s00_axis_tstrb;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_start) state_next = RECV;
            RECV: begin
                if (accept && s00_axis_tlast) begin
                    state_next = DONE;
                end else if (accept && at_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:   if (accept && s00_axis_tlast) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tready depends only on state and bram_hold, never on tvalid.
    always_comb begin
        s00_axis_tready = 1'b0;
        load_done       = 1'b0;
        case (state)
            RECV, DRAIN: s00_axis_tready = !bram_hold;
            DONE:        load_done = 1'b1;
            default:     ;
        endcase
    end

    // NOTE: the write-data register is reset because the lane outputs must
    // read zero out of reset; it is a single beat, not a memory array.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            count        <= '0;
            write_en     <= 1'b0;
            write_addr   <= '0;
            beat_q       <= '0;
            length_error <= 1'b0;
            strb_error   <= 1'b0;
        end else begin
            write_en <= accept && (state == RECV);

            if (state == IDLE && load_start) begin
                count        <= '0;
                length_error <= 1'b0;
                strb_error   <= 1'b0;
            end

            if (state == RECV && accept) begin
                write_addr <= count;
                beat_q     <= s00_axis_tdata;
                // Count saturates at the last address; overflow beats go to DRAIN.
                if (!at_last) begin
                    count <= count + ADDRESS_WIDTH'(1);
                end
                if (s00_axis_tlast != at_last) begin
                    length_error <= 1'b1;
                end
            end

            if ((state == RECV || state == DRAIN) && accept && !strb_ok) begin
                strb_error <= 1'b1;
            end
        end
    end

    assign nw_o   = beat_q[0*DATA_WIDTH +: DATA_WIDTH];
    assign w_o    = beat_q[1*DATA_WIDTH +: DATA_WIDTH];
    assign sw_o   = beat_q[2*DATA_WIDTH +: DATA_WIDTH];
    assign s_o    = beat_q[3*DATA_WIDTH +: DATA_WIDTH];
    assign se_o   = beat_q[4*DATA_WIDTH +: DATA_WIDTH];
    assign e_o    = beat_q[5*DATA_WIDTH +: DATA_WIDTH];
    assign ne_o   = beat_q[6*DATA_WIDTH +: DATA_WIDTH];
    assign n_o    = beat_q[7*DATA_WIDTH +: DATA_WIDTH];
    assign null_o = beat_q[8*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: tb/tb_axis_bram_loader.sv
// Randomized scoreboard bench for axis_bram_loader: expected BRAM writes are
// derived from each beat's frame position and checked by an independent monitor.
`timescale 1ns/1ps

module tb_axis_bram_loader;

    localparam int DEPTH = 2500;
    localparam int DW    = 16;

    logic         clk;
    logic         rst_n;
    logic         load_start;
    logic         bram_hold;
    logic         tvalid;
    logic         tready;
    logic [143:0] tdata;
    logic [17:0]  tstrb;
    logic         tlast;
    logic         write_en;
    logic [11:0]  write_addr;
    logic [15:0]  null_o, n_o, ne_o, e_o, se_o, s_o, sw_o, w_o, nw_o;
    logic         load_done;
    logic         length_error;
    logic         strb_error;
    logic [143:0] lanes;

    assign lanes = {null_o, n_o, ne_o, e_o, se_o, s_o, sw_o, w_o, nw_o};

    axis_bram_loader #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .ADDRESS_WIDTH(12)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rst_n),
        .load_start      (load_start),
        .bram_hold       (bram_hold),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tready (tready),
        .s00_axis_tdata  (tdata),
        .s00_axis_tstrb  (tstrb),
        .s00_axis_tlast  (tlast),
        .write_en        (write_en),
        .write_addr      (write_addr),
        .null_o          (null_o),
        .n_o             (n_o),
        .ne_o            (ne_o),
        .e_o             (e_o),
        .se_o            (se_o),
        .s_o             (s_o),
        .sw_o            (sw_o),
        .w_o             (w_o),
        .nw_o            (nw_o),
        .load_done       (load_done),
        .length_error    (length_error),
        .strb_error      (strb_error)
    );

    typedef struct {
        int           cyc;
        int           addr;
        logic [143:0] data;
        bit           last;
    } wr_t;

    wr_t  exp_q[$];
    int   done_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   armed    = 0;
    bit   hold_mode = 0;
    bit   exp_strb = 0;
    wr_t  mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // bram_hold asserted on every third cycle while backpressure is enabled.
    initial begin
        bram_hold = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bram_hold = hold_mode && (cyc % 3 == 0);
        end
    end

    // Monitor: compares every write and load_done against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("tready", tready, armed && !bram_hold);
            if (write_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_cycle", cyc, mon_e.cyc);
                    check("write_addr", write_addr, mon_e.addr);
                    check("write_data", lanes, mon_e.data);
                    check("done_with_write", load_done, mon_e.last);
                end
            end else if (load_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_load_done", 1, 0);
                end else begin
                    check("drain_done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    function automatic logic [143:0] pattern(input int k);
        logic [143:0] p;
        for (int i = 0; i < 9; i++) p[i*16 +: 16] = 16'(k + i * 'h1000);
        return p;
    endfunction

    function automatic logic [143:0] rand_beat();
        logic [143:0] p;
        for (int i = 0; i < 9; i++) p[i*16 +: 16] = 16'($urandom);
        return p;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_write_en"}, write_en, 0);
        check({tag, "_write_addr"}, write_addr, 0);
        check({tag, "_lanes"}, lanes, 0);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_length_error"}, length_error, 0);
        check({tag, "_strb_error"}, strb_error, 0);
        check({tag, "_tready"}, tready, 0);
    endtask

    // Offers one beat and waits (bounded) for acceptance. Model: a beat at frame
    // position k below DEPTH is written at address k one cycle later; a tlast
    // past DEPTH-1 yields a bare load_done one cycle after acceptance.
    task automatic send_beat(input int k, input logic [143:0] d, input logic [17:0] strb,
                             input bit last, output bit ok);
        tvalid = 1'b1;
        tdata  = d;
        tstrb  = strb;
        tlast  = last;
        ok     = 1'b0;
        for (int w = 0; w < 1000; w++) begin
            @(negedge clk);
            if (tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("beat_accept_timeout", 0, 1);
            return;
        end
        if (k <= DEPTH - 1) exp_q.push_back('{cyc + 1, k, d, last});
        else if (last) done_q.push_back(cyc + 1);
        if (strb != 18'h3FFFF) exp_strb = 1'b1;
        @(posedge clk);
        #1;
        if (last) armed = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        armed = 1'b0;
        exp_q.delete();
        done_q.delete();
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        // tvalid left high: nothing may be accepted or written while IDLE.
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
    endtask

    task automatic finish_frame(input bit exp_len);
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (4) @(negedge clk);
        check("writes_outstanding", exp_q.size(), 0);
        check("done_outstanding", done_q.size(), 0);
        check("length_error", length_error, exp_len);
        check("strb_error", strb_error, exp_strb);
        check("idle_tready", tready, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int n_beats, input int bad_strb_at, input bit rand_data,
                             input int gap_pct, input int reset_at, input int restart_at);
        bit           ok;
        logic [143:0] d;
        exp_strb   = 1'b0;
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        armed      = 1'b1;
        check("start_clears_length_error", length_error, 0);
        check("start_clears_strb_error", strb_error, 0);
        for (int k = 0; k < n_beats; k++) begin
            if (k == reset_at) begin
                do_reset();
                return;
            end
            for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
                tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            d = rand_data ? rand_beat() : pattern(k);
            if (k == restart_at) load_start = 1'b1;
            send_beat(k, d, (k == bad_strb_at) ? 18'h3FFFE : 18'h3FFFF, k == n_beats - 1, ok);
            load_start = 1'b0;
            if (!ok) break;
        end
        finish_frame(n_beats != DEPTH);
    endtask

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        tvalid     = 1'b0;
        tdata      = '0;
        tstrb      = '1;
        tlast      = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        hold_mode = 1'b0;
        run_frame(DEPTH, -1, 1'b0, 0, -1, -1);        // clean frame
        hold_mode = 1'b1;
        run_frame(DEPTH, -1, 1'b1, 50, -1, -1);       // backpressure + random data
        hold_mode = 1'b0;
        run_frame(100, -1, 1'b0, 0, -1, -1);          // early tlast on beat 99
        run_frame(DEPTH + 3, -1, 1'b0, 0, -1, -1);    // missing tlast, drain 3 beats
        run_frame(DEPTH, 10, 1'b0, 0, -1, -1);        // bad strobe on beat 10
        run_frame(DEPTH, 5, 1'b0, 0, 1200, -1);       // reset mid-frame
        run_frame(DEPTH, -1, 1'b1, 20, -1, 500);      // restart, stray load_start

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_bram_loader.md
Name: axis_bram_loader

Overview:
- AXI4-Stream slave that receives one frame of lattice populations, one 144-bit beat per pixel, and writes it into the nine per-direction BRAMs at pixel addresses 0..DEPTH-1.
- It is the receive-side counterpart of the BRAM-to-stream readout path and uses the identical beat packing.
- It loads initial or host-modified distributions into the LBM solver memories, and flags frame-length and strobe errors.

Parameters:
- DATA_WIDTH, 16, width of one direction population (beat width = 9*DATA_WIDTH).
- DEPTH, 2500, pixels per frame (beats expected per frame).
- ADDRESS_WIDTH, 12, BRAM write address width; must satisfy 2^ADDRESS_WIDTH >= DEPTH.

Ports:
- s00_axis_aclk  in  1  sole clock, rising edge.
- s00_axis_aresetn  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse arming a frame load; ignored unless in IDLE.
- bram_hold  in  1  solver owns the BRAM ports; stalls acceptance.
- s00_axis_tvalid  in  1  beat valid.
- s00_axis_tready  out  1  beat accept.
- s00_axis_tdata  in  144  {null,n,ne,e,se,s,sw,w,nw}; null in [143:128], nw in [15:0].
- s00_axis_tstrb  in  18  byte strobes; all ones expected.
- s00_axis_tlast  in  1  final beat of frame.
- write_en  out  1  BRAM write strobe, common to all nine BRAMs.
- write_addr  out  ADDRESS_WIDTH  pixel address.
- null_o, n_o, ne_o, e_o, se_o, s_o, sw_o, w_o, nw_o  out  16 each  per-direction write data.
- load_done  out  1  one-cycle frame-complete pulse.
- length_error  out  1  sticky: tlast position differed from DEPTH-1.
- strb_error  out  1  sticky: a beat was accepted with tstrb not all ones.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, count=0.
  - write_en, write_addr, all data outputs, load_done, length_error and strb_error are 0.
  - A partial frame is discarded; no write is issued after reset deasserts until a new load_start.
- States: IDLE, RECV, DRAIN, DONE.
- s00_axis_tready = (state==RECV or state==DRAIN) and !bram_hold. It is combinational from the state register and bram_hold only, never from tvalid.
- A beat is accepted on a rising edge where tvalid and tready are both high.
- IDLE:
  - tready=0.
  - load_start -> RECV; count<=0; length_error and strb_error cleared.
- RECV, on each accepted beat:
  - Next cycle: write_en=1, write_addr=count, the nine lanes registered from tdata.
  - count<=count+1.
  - Write latency is exactly 1 cycle from acceptance. write_en is 0 in every cycle not following an acceptance.
  - tlast with count==DEPTH-1 -> DONE.
  - tlast with count<DEPTH-1 -> length_error<=1, DONE. The beat is still written.
  - No tlast with count==DEPTH-1 -> beat written, length_error<=1, DRAIN.
- DRAIN:
  - Beats are accepted and discarded; no write_en and count is frozen.
  - Leave only on an accepted tlast -> DONE.
- DONE: load_done=1 for exactly one cycle, then -> IDLE.
  - From RECV, load_done is coincident with the write of the tlast beat.
  - From DRAIN, load_done occurs 1 cycle after the tlast acceptance.
- strb_error: set when an accepted beat in RECV or DRAIN has tstrb != 18'h3FFFF. The beat is still written, if in RECV.
- bram_hold:
  - Drops tready in the same cycle.
  - A write already registered from the previous acceptance still completes; bram_hold does not suppress an in-flight write_en.
- load_start outside IDLE: ignored; count and flags are unaffected.
- tvalid while in IDLE: not accepted; the beat waits upstream.
- count never exceeds DEPTH-1 and write_addr never exceeds DEPTH-1; no wrap-around.
- Errors stay asserted until the next accepted load_start or reset.

Test Plan:
- Clean frame, DEPTH=2500, tvalid always 1, beat k carries each lane = k plus a lane offset (0x0000..0x8000) -> 2500 write_en pulses, write_addr 0..2499 contiguous, nw_o=k and null_o=k+0x8000 at addr k; load_done one cycle, coincident with the addr-2499 write; both error flags 0.
- Backpressure: bram_hold toggled 1 every 3rd cycle, tvalid random 50% -> tready low exactly while bram_hold is high or while in IDLE/DONE; all 2500 addresses written once, in order, data intact; no duplicate or dropped write_en.
- Early tlast on beat 99 (addr 99) -> addresses 0..99 written, length_error=1, load_done coincident with the addr-99 write, return to IDLE with tready=0.
- Missing tlast, 2503 beats with tlast on the last -> addresses 0..2499 written; beats 2500..2502 accepted with no write_en; length_error=1; load_done 1 cycle after the tlast acceptance.
- tstrb=18'h3FFFE on beat 10 -> addr 10 still written with the supplied data; strb_error=1 and held after load_done; the next load_start clears it.
- Reset asserted at beat 1200, then deasserted -> all outputs 0 immediately, tready=0; a new load_start restarts at write_addr 0; load_start pulsed mid-frame has no effect on count.
